// File: rtl/mesh_ctrl_pkg.sv
// Shared types and default sizing for the mesh load sequencer.
// The sequencer top and its wait timer both import this package.
package mesh_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_COMPLETE,
        ST_FAULT
    } seq_state_t;

    localparam int NUM_ROWS_DEF  = 4;
    localparam int CONF_W_DEF    = 64;
    localparam int TIMEOUT_DEF   = 1024;
    localparam int ROW_IDX_W_DEF = $clog2(NUM_ROWS_DEF);

endpackage

// File: rtl/mesh_wait_timer.sv
// Clearable up-counter that bounds the time spent waiting for the mesh rows.
// The expired flag is high while the count sits at TIMEOUT-1, where the count holds.
module mesh_wait_timer
    import mesh_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mesh_load_sequencer.sv
// Collects per-row configuration vectors from the host, then runs one load pass:
// a single load strobe to all rows, followed by a bounded wait for every row's done flag.
module mesh_load_sequencer
    import mesh_ctrl_pkg::*;
#(
    parameter int NUM_ROWS = NUM_ROWS_DEF,
    parameter int CONF_W   = CONF_W_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [$clog2(NUM_ROWS)-1:0]  cfg_row,
    input  logic [CONF_W-1:0]            cfg_data,
    input  logic                         start,
    input  logic                         abort,
    output logic [NUM_ROWS*CONF_W-1:0]   conf_port,
    output logic                         load,
    input  logic [NUM_ROWS-1:0]          row_done,
    output logic [NUM_ROWS-1:0]          done_mask,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    seq_state_t                 r_state;
    seq_state_t                 w_next;
    logic [NUM_ROWS*CONF_W-1:0] r_conf;
    logic [NUM_ROWS-1:0]        r_written;
    logic [NUM_ROWS-1:0]        r_done_mask;
    logic                       r_error;

    logic                       w_write;
    logic                       w_start_ok;
    logic [NUM_ROWS-1:0]        w_mask_next;
    logic                       w_all_done;
    logic                       w_expired;
    logic                       w_in_wait;

    assign w_in_wait   = (r_state == ST_WAIT);
    assign w_write     = cfg_valid && (r_state == ST_IDLE);
    // Only the registered mask counts, so a write landing with start is not yet included.
    assign w_start_ok  = start && (r_state == ST_IDLE) && (&r_written);
    assign w_mask_next = r_done_mask | row_done;
    assign w_all_done  = &w_mask_next;

    mesh_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!w_in_wait),
        .enable  (w_in_wait),
        .expired (w_expired)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_start_ok) w_next = ST_LOAD;
            ST_LOAD:     w_next = abort ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                if (abort)           w_next = ST_IDLE;
                else if (w_all_done) w_next = ST_COMPLETE;
                else if (w_expired)  w_next = ST_FAULT;
            end
            ST_COMPLETE: w_next = ST_IDLE;
            ST_FAULT:    w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_conf      <= '0;
            r_written   <= '0;
            r_done_mask <= '0;
            r_error     <= 1'b0;
        end else begin
            if (w_write) begin
                r_conf[int'(cfg_row)*CONF_W +: CONF_W] <= cfg_data;
                r_written[cfg_row]                     <= 1'b1;
            end
            if (w_start_ok) begin
                r_error     <= 1'b0;
                r_done_mask <= '0;
            end else if (w_in_wait) begin
                r_done_mask <= w_mask_next;
            end
            if (w_in_wait && (w_next == ST_FAULT)) begin
                r_error <= 1'b1;
            end
        end
    end

    assign cfg_ready = (r_state == ST_IDLE);
    assign load      = (r_state == ST_LOAD);
    assign busy      = (r_state == ST_LOAD) || (r_state == ST_WAIT);
    assign done      = (r_state == ST_COMPLETE);
    assign error     = r_error;
    assign done_mask = r_done_mask;
    assign conf_port = r_conf;

endmodule

// File: doc/mesh_load_sequencer.md
Name: mesh_load_sequencer

Overview:
- Controller that sequences one configuration-and-load pass of the mesh.
- Collects one CONF_W configuration vector per mesh row from a host over a valid/ready port and holds each vector steady on the per-row configuration outputs.
- On start, issues a single-cycle load pulse to all rows, then waits until every row reports done (or a timeout expires) and signals completion or fault.
- Sits between the host/command interface and the mesh's per-row input interfaces and switches.

Parameters:
- NUM_ROWS, 4, number of mesh rows driven (power of two, ≥2).
- CONF_W, 64, configuration vector width per row.
- TIMEOUT, 1024, maximum cycles spent in WAIT before a fault (≥2).

Ports:
- clk  input  1  single clock; all state on the rising edge.
- reset  input  1  asynchronous reset, active-high.
- cfg_valid  input  1  host offers a configuration word.
- cfg_ready  output  1  sequencer accepts a configuration word this cycle.
- cfg_row  input  $clog2(NUM_ROWS)  target row of the offered word.
- cfg_data  input  CONF_W  configuration vector.
- start  input  1  request a load pass.
- abort  input  1  cancel an in-progress pass.
- conf_port  output  NUM_ROWS×CONF_W  held configuration vector per row, to the mesh.
- load  output  1  one-cycle load strobe to all rows.
- row_done  input  NUM_ROWS  per-row done flags from the mesh.
- done_mask  output  NUM_ROWS  rows seen done in the current/last pass.
- busy  output  1  pass in progress (LOAD or WAIT).
- done  output  1  one-cycle pulse when a pass completes.
- error  output  1  sticky timeout flag.

Behaviour:
- Reset values: state=IDLE, conf_port=0, written mask=0, done_mask=0, load=0, busy=0, done=0, error=0, cfg_ready=1.
- States: IDLE, LOAD, WAIT, COMPLETE, FAULT. All outputs are decoded from registered state or registers; none is combinational from inputs.
- cfg_ready=1 only in IDLE.
- A write occurs on cfg_valid&cfg_ready. It sets conf_port[cfg_row] and written[cfg_row] at the next edge.
- Writes outside IDLE are not accepted, because cfg_ready=0 there.
- IDLE→LOAD when start=1 and the registered written mask is all ones.
  - A write in the same cycle does not count toward that check, but its data is visible on conf_port during LOAD.
  - start with an incomplete mask is ignored and leaves no side effects.
- On accepting start: error←0 and done_mask←0.
- The written mask persists after a pass. Re-running with the same configuration needs only start.
- LOAD lasts exactly 1 cycle with load=1 and busy=1, then goes to WAIT. If start is accepted in cycle T, load is high in cycle T+1.
- WAIT: busy=1. Each cycle, done_mask←done_mask|row_done. row_done is ignored outside WAIT.
  - If (done_mask|row_done) is all ones, next state is COMPLETE.
  - Otherwise, if the timer equals TIMEOUT-1, next state is FAULT.
  - Otherwise the timer increments. The timer clears on entering WAIT.
  - If completion and timeout occur in the same cycle, COMPLETE wins.
- COMPLETE: done=1 for 1 cycle, then IDLE. If all rows are done in the first WAIT cycle (T+2), done pulses at T+3.
- FAULT: error←1 (sticky until the next accepted start or reset) for 1 cycle, then IDLE. done is not pulsed. done_mask keeps the partial result for diagnosis.
- abort in LOAD or WAIT: next state is IDLE. No done, error unchanged, done_mask retained.
  - abort in LOAD still leaves that cycle's load pulse high; the mesh is not un-loaded.
  - abort in IDLE, COMPLETE or FAULT is ignored.
  - abort has priority over completion and timeout in the same cycle.
- Asynchronous reset mid-pass: all state returns immediately to the reset values, and load drops without waiting for an edge.

Decomposition:
- Package mesh_ctrl_pkg holds:
  - the state enum (seq_state_t);
  - default NUM_ROWS, CONF_W and TIMEOUT constants;
  - the row index width localparam.
- One sub-module, mesh_wait_timer: clearable up-counter with terminal-count flag (parameter TIMEOUT; ports clk, reset, clear, enable, expired).
- Everything else stays in the top module.

Test Plan:
- Write rows 0..3 with 64'hA0..A3 and start; raise row_done=4'b1111 in the first WAIT cycle → conf_port holds A0..A3, load high exactly 1 cycle at T+1, done pulse at T+3, done_mask=4'b1111, busy low at T+4.
- Write rows 0,1,2 only, then start → no load, state stays IDLE. Write row 3 and start → normal pass.
- Staggered completion: row_done bits rise one per cycle (0,1,2,3), each for 1 cycle only → done_mask accumulates, and done pulses the cycle after the 4th bit.
- TIMEOUT=16, row_done=4'b0111 held → error=1 after 16 WAIT cycles, no done pulse, done_mask=4'b0111. The next start clears error.
- abort in the 3rd WAIT cycle while row_done=4'b1111 in the same cycle → returns to IDLE, no done, error=0. cfg_valid is refused (cfg_ready=0) during LOAD/WAIT.
- Assert reset during WAIT → all outputs return immediately to reset values (load=0, conf_port=0), and start without fresh writes is ignored.
